// File: rtl/ctr_sched_pkg.sv
// ctr_sched_pkg: shared state encoding and default sizing for the counter scheduler
package ctr_sched_pkg;
    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 3;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/ctr_sched_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit starting at ptr and wrapping
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [PW-1:0]   idx,
    output logic            any
);
    always_comb begin
        idx = '0;
        any = |req;
        // scan farthest offset first so the nearest set bit to ptr wins
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) idx = PW'((int'(ptr) + k) % NREQ);
        pick = any ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/ctr_sched.sv
// ctr_sched: round-robin shared-counter scheduler granting (len+1)-cycle counting windows
module ctr_sched
    import ctr_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*CW-1:0] len,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic [NREQ-1:0]  done,
    output logic [CW-1:0]    cnt_o,
    output logic             ovflo_o
);
    localparam int PW = $clog2(NREQ);
    state_t          state, state_n;
    logic [NREQ-1:0] gnt_n, done_n, pick;
    logic [CW-1:0]   cnt_n, len_q, len_n;
    logic [PW-1:0]   ptr, ptr_n, win, win_n, idx, win_nx;
    logic            any;
    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (idx),
        .any  (any)
    );
    assign win_nx  = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign busy    = (state == ST_RUN);
    assign ovflo_o = busy & (&cnt_o);
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        done_n  = '0;
        cnt_n   = cnt_o;
        len_n   = len_q;
        ptr_n   = ptr;
        win_n   = win;
        case (state)
            ST_RUN: begin
                // abort outranks completion on the same edge
                if (!req[win] || cnt_o == len_q) begin
                    state_n = req[win] ? ST_DONE : ST_IDLE;
                    done_n  = req[win] ? gnt : '0;
                    gnt_n   = '0;
                    ptr_n   = win_nx;
                end else begin
                    cnt_n = cnt_o + 1'b1;
                end
            end
            default: begin
                state_n = any ? ST_RUN : ST_IDLE;
                gnt_n   = pick;
                if (any) begin
                    win_n = idx;
                    len_n = len[int'(idx)*CW +: CW];
                    cnt_n = '0;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= '0;
            done  <= '0;
            cnt_o <= '0;
            len_q <= '0;
            ptr   <= '0;
            win   <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            done  <= done_n;
            cnt_o <= cnt_n;
            len_q <= len_n;
            ptr   <= ptr_n;
            win   <= win_n;
        end
    end
endmodule

// File: tb/tb_ctr_sched.sv
// tb_ctr_sched: directed self-checking bench for ctr_sched with hand-computed expectations
module tb_ctr_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] len;
    logic [3:0]  gnt, done;
    logic        busy, ovflo_o;
    logic [2:0]  cnt_o;
    int          checks = 0;
    int          errors = 0;

    ctr_sched #(.NREQ(4), .CW(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .len     (len),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .cnt_o   (cnt_o),
        .ovflo_o (ovflo_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input string tag, input logic [3:0] g, input logic [3:0] d,
                      input logic b, input logic [2:0] c, input logic o);
        logic [12:0] obs, exp;
        obs = {gnt, done, busy, cnt_o, ovflo_o};
        exp = {g, d, b, c, o};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got gnt=%b done=%b busy=%b cnt=%0d ovflo=%b, expected gnt=%b done=%b busy=%b cnt=%0d ovflo=%b",
                   tag, gnt, done, busy, cnt_o, ovflo_o, g, d, b, c, o);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        len   = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ex("reset_hold", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        ex("first_grant_r0", 4'b0001, 4'b0000, 1'b1, 3'd0, 1'b0);
        req = 4'b0000;
        tick();
        ex("abort_after_reset", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0);

        // single window on requester 1, len=3
        len = 12'(3) << 3;
        req = 4'b0010;
        tick();
        ex("single_c0", 4'b0010, 4'b0000, 1'b1, 3'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            ex("single_run", 4'b0010, 4'b0000, 1'b1, 3'(k), 1'b0);
        end
        tick();
        ex("single_done", 4'b0000, 4'b0010, 1'b0, 3'd3, 1'b0);
        req = 4'b0000;
        tick();
        ex("single_idle", 4'b0000, 4'b0000, 1'b0, 3'd3, 1'b0);

        // round-robin from a fresh pointer
        rst_n = 1'b0;
        tick();
        ex("rr_reset", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        len   = '0;
        req   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            ex("rr_grant", 4'(1 << i), 4'b0000, 1'b1, 3'd0, 1'b0);
            tick();
            ex("rr_done", 4'b0000, 4'(1 << i), 1'b0, 3'd0, 1'b0);
        end
        tick();
        ex("rr_wrap_grant", 4'b0001, 4'b0000, 1'b1, 3'd0, 1'b0);
        req = 4'b0000;
        tick();
        ex("rr_abort", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0);

        // abort mid-window, pointer now at 1
        len = 12'd5;
        req = 4'b0001;
        tick();
        ex("abort_c0", 4'b0001, 4'b0000, 1'b1, 3'd0, 1'b0);
        tick();
        tick();
        ex("abort_c2", 4'b0001, 4'b0000, 1'b1, 3'd2, 1'b0);
        req = 4'b0000;
        tick();
        ex("abort_drop", 4'b0000, 4'b0000, 1'b0, 3'd2, 1'b0);
        req = 4'b0011;
        tick();
        ex("abort_next_r1", 4'b0010, 4'b0000, 1'b1, 3'd0, 1'b0);
        req = 4'b0000;
        tick();
        ex("abort_r1_drop", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0);

        // overflow window on requester 2, len=7
        len = 12'(7) << 6;
        req = 4'b0100;
        tick();
        ex("ovf_c0", 4'b0100, 4'b0000, 1'b1, 3'd0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            ex("ovf_run", 4'b0100, 4'b0000, 1'b1, 3'(k), k == 7);
        end
        tick();
        ex("ovf_done", 4'b0000, 4'b0100, 1'b0, 3'd7, 1'b0);
        req = 4'b0000;
        tick();
        ex("ovf_idle", 4'b0000, 4'b0000, 1'b0, 3'd7, 1'b0);

        // reset in the middle of a window
        req = 4'b0100;
        tick();
        ex("rst_mid_c0", 4'b0100, 4'b0000, 1'b1, 3'd0, 1'b0);
        for (int k = 1; k <= 4; k++) tick();
        ex("rst_mid_c4", 4'b0100, 4'b0000, 1'b1, 3'd4, 1'b0);
        rst_n = 1'b0;
        tick();
        ex("rst_mid_clear", 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        ex("rst_mid_ptr0", 4'b0001, 4'b0000, 1'b1, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
